// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: writeback buffer FIFO in front of the register file write port, with operand forwarding
module regfile_wb_queue #(
  parameter int REG_COUNT    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int ZERO_PROTECT = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_valid_i,
  output logic                         wb_ready_o,
  input  logic [$clog2(REG_COUNT)-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]        wb_data_i,
  input  logic                         stall_i,
  output logic                         write_en_o,
  output logic [$clog2(REG_COUNT)-1:0] write_addr_o,
  output logic [DATA_WIDTH-1:0]        write_data_o,
  input  logic [$clog2(REG_COUNT)-1:0] fwd_addr1_i,
  input  logic [$clog2(REG_COUNT)-1:0] fwd_addr2_i,
  output logic                         fwd_hit1_o,
  output logic                         fwd_hit2_o,
  output logic [DATA_WIDTH-1:0]        fwd_data1_o,
  output logic [DATA_WIDTH-1:0]        fwd_data2_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(REG_COUNT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0]         addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, cnt_v;
  logic                  push, pop;
  logic [DATA_WIDTH:0]   look1, look2;
  // Youngest valid entry matching a; the head is oldest, so the last match in walk order wins.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [AW-1:0] a);
    lookup = '0;
    for (int k = 0; k < DEPTH; k++)
      if (CW'(k) < cnt_v && addr_mem[rd_ptr + PW'(k)] == a && !(ZERO_PROTECT != 0 && a == '0))
        lookup = {1'b1, data_mem[rd_ptr + PW'(k)]};
  endfunction
  // Visible occupancy is forced to zero while reset is held, which blanks every output.
  always_comb begin
    cnt_v        = rst_i ? '0 : count;
    count_o      = cnt_v;
    wb_ready_o   = cnt_v != CW'(DEPTH);
    push         = wb_valid_i && wb_ready_o && !(ZERO_PROTECT != 0 && wb_addr_i == '0);
    write_en_o   = cnt_v != '0 && !stall_i;
    pop          = write_en_o;
    write_addr_o = cnt_v != '0 ? addr_mem[rd_ptr] : '0;
    write_data_o = cnt_v != '0 ? data_mem[rd_ptr] : '0;
    look1        = lookup(fwd_addr1_i);
    look2        = lookup(fwd_addr2_i);
    fwd_hit1_o   = look1[DATA_WIDTH];
    fwd_hit2_o   = look2[DATA_WIDTH];
    fwd_data1_o  = look1[DATA_WIDTH-1:0];
    fwd_data2_o  = look2[DATA_WIDTH-1:0];
  end
  // Pointer and occupancy update; push and pop in the same cycle keep the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Entry storage carries no reset; validity comes only from the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= wb_addr_i;
      data_mem[wr_ptr] <= wb_data_i;
    end
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed and randomized checks against a queue-based reference model
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  logic clk = 0;
  logic rst, valid, stall;
  logic [4:0] addr, fa1, fa2;
  logic [31:0] data;
  logic ready, we, hit1, hit2;
  logic [4:0] waddr;
  logic [31:0] wdata, fd1, fd2;
  logic [2:0] cnt;
  int checks = 0;
  int errors = 0;
  bit model_on = 0;
  ent_t q[$];

  regfile_wb_queue #(.REG_COUNT(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .ZERO_PROTECT(1)) dut (
    .clk_i(clk), .rst_i(rst), .wb_valid_i(valid), .wb_ready_o(ready), .wb_addr_i(addr),
    .wb_data_i(data), .stall_i(stall), .write_en_o(we), .write_addr_o(waddr),
    .write_data_o(wdata), .fwd_addr1_i(fa1), .fwd_addr2_i(fa2), .fwd_hit1_o(hit1),
    .fwd_hit2_o(hit2), .fwd_data1_o(fd1), .fwd_data2_o(fd2), .count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] mfwd(input logic [4:0] a);
    if (a == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a) return {1'b1, q[i].d};
    return '0;
  endfunction

  // Reference model: a plain queue, pop from the front and push to the back at each edge.
  always @(posedge clk) begin
    if (rst) q.delete();
    else begin
      automatic bit do_pop = q.size() != 0 && !stall;
      automatic bit do_push = valid && q.size() != DEPTH && addr != 0;
      automatic ent_t e;
      e.a = addr;
      e.d = data;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      automatic int n = rst ? 0 : q.size();
      automatic logic [32:0] f1 = rst ? 33'd0 : mfwd(fa1);
      automatic logic [32:0] f2 = rst ? 33'd0 : mfwd(fa2);
      check("m_count", 32'(cnt), 32'(n));
      check("m_ready", 32'(ready), 32'(n != DEPTH));
      check("m_we", 32'(we), 32'(n != 0 && !stall));
      check("m_waddr", 32'(waddr), n != 0 ? 32'(q[0].a) : 32'd0);
      check("m_wdata", wdata, n != 0 ? q[0].d : 32'd0);
      check("m_hit1", 32'(hit1), 32'(f1[32]));
      check("m_hit2", 32'(hit2), 32'(f2[32]));
      check("m_fd1", fd1, f1[31:0]);
      check("m_fd2", fd2, f2[31:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    valid = v;
    addr = a;
    data = d;
  endtask

  initial begin
    rst = 1; valid = 0; stall = 0; addr = 0; data = 0; fa1 = 0; fa2 = 0;
    tick();
    model_on = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("reset_count", 32'(cnt), 0);
    check("reset_ready", 32'(ready), 1);
    check("reset_we", 32'(we), 0);
    tick();
    // single push drains after one cycle
    drive(1, 5, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0);
    @(negedge clk);
    check("lat_we", 32'(we), 1);
    check("lat_addr", 32'(waddr), 5);
    check("lat_data", wdata, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("lat_we_after", 32'(we), 0);
    check("lat_count_after", 32'(cnt), 0);
    // register 0 write accepted but discarded
    tick();
    drive(1, 0, 32'hFFFFFFFF);
    fa1 = 0;
    @(negedge clk);
    check("zero_ready", 32'(ready), 1);
    tick();
    drive(0, 0, 0);
    @(negedge clk);
    check("zero_count", 32'(cnt), 0);
    check("zero_we", 32'(we), 0);
    check("zero_hit", 32'(hit1), 0);
    // fill under stall, hold the fifth, then drain in order
    tick();
    stall = 1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 32'h100 + i);
      tick();
    end
    drive(1, 5, 32'h555);
    @(negedge clk);
    check("full_count", 32'(cnt), 4);
    check("full_ready", 32'(ready), 0);
    tick();
    @(negedge clk);
    check("full_held", 32'(cnt), 4);
    tick();
    drive(0, 0, 0);
    stall = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("drain_we", 32'(we), 1);
      check("drain_addr", 32'(waddr), 32'(i));
      check("drain_data", wdata, 32'h100 + i);
      tick();
    end
    @(negedge clk);
    check("drain_empty", 32'(cnt), 0);
    // forwarding picks the youngest matching entry
    tick();
    stall = 1;
    drive(1, 10, 32'h11111111);
    tick();
    drive(1, 10, 32'h22222222);
    tick();
    drive(0, 0, 0);
    fa1 = 10;
    fa2 = 7;
    @(negedge clk);
    check("fwd_hit1", 32'(hit1), 1);
    check("fwd_data1", fd1, 32'h22222222);
    check("fwd_hit2", 32'(hit2), 0);
    tick();
    stall = 0;
    tick();
    tick();
    // steady push+pop with two entries resident, wrapping the pointers
    stall = 1;
    drive(1, 1, 32'hA1);
    tick();
    drive(1, 2, 32'hA2);
    tick();
    stall = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 5'(k + 3), 32'hA3 + k);
      @(negedge clk);
      check("wrap_count", 32'(cnt), 2);
      check("wrap_addr", 32'(waddr), 32'(k + 1));
      tick();
    end
    drive(0, 0, 0);
    @(negedge clk);
    check("wrap_tail", 32'(waddr), 9);
    tick();
    tick();
    // reset mid-operation drops the queue and the concurrent push
    stall = 1;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(i + 20), 32'hB0 + i);
      tick();
    end
    rst = 1;
    drive(1, 20, 32'hCC);
    tick();
    rst = 0;
    stall = 0;
    drive(0, 0, 0);
    @(negedge clk);
    check("rst_mid_count", 32'(cnt), 0);
    check("rst_mid_we", 32'(we), 0);
    tick();
    @(negedge clk);
    check("rst_mid_we2", 32'(we), 0);
    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = $urandom_range(0, 99) == 0;
      valid = $urandom_range(0, 1) != 0;
      addr = 5'($urandom_range(0, 7));
      data = $urandom;
      stall = $urandom_range(0, 9) < 3;
      fa1 = 5'($urandom_range(0, 7));
      fa2 = 5'($urandom_range(0, 7));
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
